traffic_spawn_scheduler: RTL and testbench

TRAFFIC_SPAWN_SCHEDULER -- requirements
Module: traffic_spawn_scheduler

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/slot_eligibility_check.sv | 35 +++
 rtl/traffic_spawn_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_traffic_spawn_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the traffic spawn scheduler:
//   - state_e       : scheduler FSM state encoding
//   - NUM_SLOTS_DEF : default number of enemy-car slots
//   - NO_SLOT       : lastSlot value meaning "nothing released yet"
//   - BASE_GAP_DEF / MIN_GAP_DEF : default pacing constants (tick pulses)
//   - gap_calc()    : inter-release gap for a given player speed
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_SEARCH = 2'd2,
    ST_FIRE   = 2'd3
  } state_e;

  localparam int          NUM_SLOTS_DEF = 9;
  localparam logic [3:0]  NO_SLOT       = 4'hF;
  localparam int          BASE_GAP_DEF  = 8;
  localparam int          MIN_GAP_DEF   = 2;

  // max(base_gap - speed, min_gap), done in signed int so a speed larger
  // than base_gap cannot wrap to a huge unsigned gap.
  function automatic logic [7:0] gap_calc(input int base_gap,
                                          input int min_gap,
                                          input logic [3:0] speed);
    int diff;
    diff = base_gap - int'({28'd0, speed});
    if (diff < min_gap) diff = min_gap;
    return diff[7:0];
  endfunction

endpackage

// File: rtl/slot_eligibility_check.sv
// slot_eligibility_check
//   Flags which slots may be released next. A slot is eligible when its
//   ready bit is set and it is not the slot released last time, unless that
//   slot is the only ready one (a repeat is better than starving the road).
// Ports
//   ready_i     [NUM_SLOTS] per-slot idle flags
//   last_slot_i [4]         most recently released slot, 4'hF = none
//   eligible_o  [NUM_SLOTS] per-slot eligible flags
module slot_eligibility_check
  import traffic_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF
) (
  input  logic [NUM_SLOTS-1:0] ready_i,
  input  logic [3:0]           last_slot_i,
  output logic [NUM_SLOTS-1:0] eligible_o
);

  logic [NUM_SLOTS-1:0] last_mask;
  logic                 sole_last;

  always_comb begin
    last_mask  = '0;
    eligible_o = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (last_slot_i == 4'(i)) last_mask[i] = 1'b1;
    end
    // NO_SLOT gives an empty mask, so nothing is treated as a repeat.
    sole_last = (last_mask != '0) && (ready_i == last_mask);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      eligible_o[i] = ready_i[i] && (!last_mask[i] || sole_last);
    end
  end

endmodule

// File: rtl/traffic_spawn_scheduler.sv
// traffic_spawn_scheduler
//   Paces enemy-car releases: waits a speed-dependent number of tick pulses,
//   then scans the slots round-robin from a random start and releases the
//   first eligible one with a one-cycle one-hot pulse.
// Ports
//   clk          system clock
//   resetN       asynchronous active-low reset
//   tick         one-cycle pacing strobe
//   ready        [NUM_SLOTS] per-slot "car idle" flags
//   randomizer   [4] random search start index
//   playerspeed  [4] player speed, 0 = stopped
//   releaseCar   [NUM_SLOTS] one-hot release pulse
//   lastSlot     [4] last released slot, 4'hF = none
//   busy         high whenever the FSM is not idle
//   spawnCount   [8] saturating release counter
// Build option
//   SPAWN_COUNT_EN : when defined, spawnCount counts releases (saturating at
//                    255); otherwise it is tied to zero.
//
// state  | meaning
// IDLE   | player stopped, nothing scheduled
// GAP    | counting tick pulses down to the next release attempt
// SEARCH | examining one slot per cycle for an eligible car
// FIRE   | one-cycle release pulse for the selected slot
module traffic_spawn_scheduler
  import traffic_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int BASE_GAP  = BASE_GAP_DEF,
  parameter int MIN_GAP   = MIN_GAP_DEF
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 tick,
  input  logic [NUM_SLOTS-1:0] ready,
  input  logic [3:0]           randomizer,
  input  logic [3:0]           playerspeed,
  output logic [NUM_SLOTS-1:0] releaseCar,
  output logic [3:0]           lastSlot,
  output logic                 busy,
  output logic [7:0]           spawnCount
);

  localparam logic [3:0] SLOT_MAX  = 4'(NUM_SLOTS - 1);
  localparam logic [3:0] SLOT_CNT  = 4'(NUM_SLOTS);

  state_e               state_q, state_d;
  logic [7:0]           gap_q, gap_d;
  logic [3:0]           ptr_q, ptr_d;
  logic [3:0]           exam_q, exam_d;
  logic [3:0]           sel_q, sel_d;
  logic [3:0]           last_q, last_d;
  logic                 fire;
  logic [7:0]           gap_reload;
  logic [3:0]           ptr_start;
  logic [NUM_SLOTS-1:0] eligible;
  logic                 hit;

  slot_eligibility_check #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_elig (
    .ready_i     (ready),
    .last_slot_i (last_q),
    .eligible_o  (eligible)
  );

  assign gap_reload = gap_calc(BASE_GAP, MIN_GAP, playerspeed);
  // randomizer spans 0..15, so one subtraction folds it into range.
  assign ptr_start  = (randomizer <= SLOT_MAX) ? randomizer
                                               : randomizer - SLOT_CNT;
  assign hit        = eligible[ptr_q];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      gap_q   <= 8'd0;
      ptr_q   <= 4'd0;
      exam_q  <= 4'd0;
      sel_q   <= 4'd0;
      last_q  <= NO_SLOT;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      exam_q  <= exam_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    exam_d  = exam_q;
    sel_d   = sel_q;
    last_d  = last_q;
    fire    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (playerspeed != 4'd0) begin
          state_d = ST_GAP;
          gap_d   = gap_reload;
        end
      end

      ST_GAP: begin
        if (tick) begin
          if (gap_q > 8'd1) begin
            gap_d = gap_q - 8'd1;
          end else begin
            state_d = ST_SEARCH;
            ptr_d   = ptr_start;
            exam_d  = 4'd0;
          end
        end
      end

      ST_SEARCH: begin
        if (hit) begin
          state_d = ST_FIRE;
          sel_d   = ptr_q;
        end else if (exam_q == SLOT_MAX) begin
          // Every slot examined once without a hit: wait a full gap again.
          state_d = ST_GAP;
          gap_d   = gap_reload;
        end else begin
          ptr_d  = (ptr_q == SLOT_MAX) ? 4'd0 : ptr_q + 4'd1;
          exam_d = exam_q + 4'd1;
        end
      end

      ST_FIRE: begin
        fire    = 1'b1;
        last_d  = sel_q;
        gap_d   = gap_reload;
        state_d = ST_GAP;
      end

      default: state_d = ST_IDLE;
    endcase

    // A stopped player aborts everything, including a pending release.
    if (playerspeed == 4'd0) begin
      state_d = ST_IDLE;
      fire    = 1'b0;
      last_d  = last_q;
    end
  end

  always_comb begin
    releaseCar = '0;
    if (fire) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (sel_q == 4'(i)) releaseCar[i] = 1'b1;
      end
    end
  end

  assign lastSlot = last_q;
  assign busy     = (state_q != ST_IDLE);

`ifdef SPAWN_COUNT_EN
  logic [7:0] spawn_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      spawn_q <= 8'd0;
    end else if (fire && (spawn_q != 8'hFF)) begin
      spawn_q <= spawn_q + 8'd1;
    end
  end

  assign spawnCount = spawn_q;
`else
  assign spawnCount = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_spawn_scheduler.sv
module tb_traffic_spawn_scheduler;

  localparam int NS = 9;

  logic          clk;
  logic          resetN;
  logic          tick;
  logic [NS-1:0] ready;
  logic [3:0]    randomizer;
  logic [3:0]    playerspeed;
  logic [NS-1:0] releaseCar;
  logic [3:0]    lastSlot;
  logic          busy;
  logic [7:0]    spawnCount;

  int checks = 0;
  int errors = 0;

  traffic_spawn_scheduler #(
    .NUM_SLOTS (9),
    .BASE_GAP  (8),
    .MIN_GAP   (2)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .tick        (tick),
    .ready       (ready),
    .randomizer  (randomizer),
    .playerspeed (playerspeed),
    .releaseCar  (releaseCar),
    .lastSlot    (lastSlot),
    .busy        (busy),
    .spawnCount  (spawnCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model thinks in terms of "ticks still owed" and "cycles until the
  // outcome of the current scan", with the scan resolved in one go.
  int         m_active, m_waiting, m_ticks_left, m_pending, m_event_in, m_fire;
  int         m_sel, m_last, m_count;

  function automatic int gap_of(input int s);
    int g;
    g = 8 - s;
    return (g < 2) ? 2 : g;
  endfunction

  task automatic model_reset();
    m_active = 0; m_waiting = 0; m_ticks_left = 0; m_pending = 0;
    m_event_in = 0; m_fire = 0; m_sel = 0; m_last = 15; m_count = 0;
  endtask

  task automatic model_scan();
    int start, idx;
    start = (int'(randomizer) < NS) ? int'(randomizer) : int'(randomizer) - NS;
    m_fire = 0;
    m_event_in = NS - 1;
    for (int j = 0; j < NS; j++) begin
      idx = (start + j) % NS;
      if (m_fire == 0 && ready[idx] &&
          (idx != m_last || $countones(ready) == 1)) begin
        m_fire = 1;
        m_sel = idx;
        m_event_in = j + 1;
      end
    end
  endtask

  task automatic model_advance();
    int s;
    s = int'(playerspeed);
    if (s == 0) begin
      m_active = 0; m_waiting = 0; m_pending = 0;
    end else if (m_active == 0) begin
      m_active = 1; m_waiting = 1; m_ticks_left = gap_of(s);
    end else if (m_waiting != 0) begin
      if (tick) begin
        m_ticks_left--;
        if (m_ticks_left == 0) begin
          m_waiting = 0;
          m_pending = 1;
          model_scan();
        end
      end
    end else if (m_pending != 0) begin
      if (m_event_in == 0) begin
        if (m_fire != 0) begin
          m_last = m_sel;
          if (m_count < 255) m_count++;
        end
        m_pending = 0; m_waiting = 1; m_ticks_left = gap_of(s);
      end else begin
        m_event_in--;
      end
    end
  endtask

  function automatic logic [NS-1:0] exp_release();
    logic [NS-1:0] one;
    one = 1;
    if (m_pending != 0 && m_fire != 0 && m_event_in == 0 && playerspeed != 4'd0)
      return one << m_sel;
    return '0;
  endfunction

  function automatic logic [7:0] exp_count();
`ifdef SPAWN_COUNT_EN
    return 8'(m_count);
`else
    return 8'd0;
`endif
  endfunction

  initial begin
    model_reset();
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!resetN) model_reset();
      chk("cyc_releaseCar", 32'(releaseCar), 32'(exp_release()));
      chk("cyc_lastSlot",   32'(lastSlot),   32'(m_last));
      chk("cyc_busy",       32'(busy),       32'(m_active != 0));
      chk("cyc_spawnCount", 32'(spawnCount), 32'(exp_count()));
      @(posedge clk);
      if (!resetN) model_reset();
      else model_advance();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n tick pulses, one idle cycle between them; returns in the cycle after
  // the final (gap-expiring) tick.
  task automatic expire(input int n);
    for (int i = 0; i < n - 1; i++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
    end
    tick = 1'b1; step(); tick = 1'b0;
  endtask

  // Latency counted in cycles after the expiring tick's cycle.
  task automatic wait_pulse(input int max_lat, output int lat, output logic [NS-1:0] rel);
    lat = 1;
    while (releaseCar == '0 && lat < max_lat) begin
      step();
      lat++;
    end
    rel = releaseCar;
  endtask

  int            lat;
  logic [NS-1:0] rel;
  int            pulses;
  logic [NS-1:0] exp_rel [3];
  int            exp_lat [3];

  initial begin
    resetN = 1'b0; tick = 1'b0; ready = '0; randomizer = 4'd0; playerspeed = 4'd0;
    repeat (3) step();
    chk("rst_releaseCar", 32'(releaseCar), 32'h0);
    chk("rst_lastSlot",   32'(lastSlot),   32'hF);
    chk("rst_busy",       32'(busy),       32'h0);
    chk("rst_spawnCount", 32'(spawnCount), 32'h0);
    resetN = 1'b1;
    step();

    // Release rate: speed 3 -> gap 5, start at slot 4.
    ready = 9'h1FF; randomizer = 4'd4;
    step(); step();
    chk("idle_stays", 32'(busy), 32'h0);
    playerspeed = 4'd3;
    step();
    chk("gap_busy", 32'(busy), 32'h1);
    expire(5);
    chk("s1_search_no_pulse", 32'(releaseCar), 32'h0);
    step();
    ready = '0;                     // drop after examination: selection kept
    #1;
    chk("s1_release", 32'(releaseCar), 32'h010);
    step();
    chk("s1_lastSlot", 32'(lastSlot), 32'h4);
    ready = 9'h1FF;

    // Repeat avoidance then sole-candidate repeat.
    ready = 9'h011; randomizer = 4'd4;
    expire(5); wait_pulse(12, lat, rel);
    chk("s2_release", 32'(rel), 32'h001);
    chk("s2_latency", 32'(lat), 32'd7);
    step();
    chk("s2_lastSlot", 32'(lastSlot), 32'h0);
    ready = 9'h010;
    expire(5); wait_pulse(12, lat, rel);
    chk("s2b_release", 32'(rel), 32'h010);
    chk("s2b_latency", 32'(lat), 32'd2);
    step();
    expire(5); wait_pulse(12, lat, rel);
    chk("s2c_sole_repeat", 32'(rel), 32'h010);
    chk("s2c_latency", 32'(lat), 32'd2);
    step();

    // Out-of-range start 13 -> 4, wraps 8->0, hits slot 2.
    ready = 9'h004; randomizer = 4'd13;
    expire(5); wait_pulse(12, lat, rel);
    chk("s3_release", 32'(rel), 32'h004);
    chk("s3_latency", 32'(lat), 32'd9);
    step();
    chk("s3_lastSlot", 32'(lastSlot), 32'h2);

    // Empty search: nine SEARCH cycles, then GAP with a fresh 5-tick gap.
    ready = '0; randomizer = 4'd0;
    expire(5);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      if (releaseCar != '0) pulses++;
      if (i == 8) chk("s4_busy_last_search", 32'(busy), 32'h1);
      step();
    end
    chk("s4_no_pulse", 32'(pulses), 32'd0);
    ready = 9'h1FF; randomizer = 4'd5;
    expire(5); wait_pulse(12, lat, rel);
    chk("s4_regap_release", 32'(rel), 32'h020);
    chk("s4_regap_latency", 32'(lat), 32'd2);
    step();

    // Abort in FIRE.
    randomizer = 4'd0;
    expire(5);
    step();
    playerspeed = 4'd0;
    #1;
    chk("s5_abort_release", 32'(releaseCar), 32'h0);
    step();
    chk("s5_abort_idle", 32'(busy), 32'h0);
    chk("s5_abort_lastSlot", 32'(lastSlot), 32'h5);

    // Reset in the middle of a search.
    playerspeed = 4'd3;
    step();
    ready = '0;
    expire(5); step(); step();
    chk("s6_mid_search_busy", 32'(busy), 32'h1);
    resetN = 1'b0;
    #1;
    chk("s6_rst_releaseCar", 32'(releaseCar), 32'h0);
    chk("s6_rst_lastSlot",   32'(lastSlot),   32'hF);
    chk("s6_rst_busy",       32'(busy),       32'h0);
    chk("s6_rst_spawnCount", 32'(spawnCount), 32'h0);
    step();
    resetN = 1'b1;

    // Gap floor: speed 15 -> every 2 ticks.
    playerspeed = 4'd15; ready = 9'h1FF; randomizer = 4'd0;
    step();
    exp_rel[0] = 9'h001; exp_lat[0] = 2;
    exp_rel[1] = 9'h002; exp_lat[1] = 3;
    exp_rel[2] = 9'h001; exp_lat[2] = 2;
    for (int i = 0; i < 3; i++) begin
      expire(2); wait_pulse(12, lat, rel);
      chk("s7_floor_release", 32'(rel), 32'(exp_rel[i]));
      chk("s7_floor_latency", 32'(lat), 32'(exp_lat[i]));
      step();
    end
`ifdef SPAWN_COUNT_EN
    chk("s7_spawnCount", 32'(spawnCount), 32'd3);
`else
    chk("s7_spawnCount", 32'(spawnCount), 32'd0);
`endif

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
